// File: rtl/param_seq_fsm.sv
// param_seq_fsm -- parameterised state sequencer with one two-way branch.
//
// Steps through states 0..NUM_ST-1 and wraps to 0. From state BR_ST the
// sequence goes to BR_ST+1 when control=1, or skips to BR_ST+2 when
// control=0. Outputs are registered on the same edge as the state.
//
// Optional feature (macro SEQ_DWELL_EN): when defined, each state is held
// for DWELL enabled cycles before advancing. When undefined, every enabled
// cycle advances and DWELL is ignored. The port list is identical either way.
//
// Ports
//   clock   in   1   rising-edge clock
//   reset   in   1   asynchronous active-low reset
//   enable  in   1   advance qualifier; 0 holds state, y and dwell count
//   control in   1   branch select, used only when advancing out of BR_ST
//   y       out  YW  (state+1) truncated to YW bits, registered
//   state   out  SW  current state index
//   wrap    out  1   one-cycle pulse after the edge moving NUM_ST-1 -> 0
module param_seq_fsm #(
  parameter int NUM_ST = 4,
  parameter int YW     = 3,
  parameter int BR_ST  = 1,
  parameter int DWELL  = 1,
  localparam int SW    = $clog2(NUM_ST)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          control,
  output logic [YW-1:0] y,
  output logic [SW-1:0] state,
  output logic          wrap
);

  typedef logic [SW-1:0] st_t;

  localparam st_t LAST  = st_t'(NUM_ST - 1);
  localparam st_t BR    = st_t'(BR_ST);
  localparam st_t BR_T  = st_t'(BR_ST + 1);
  localparam st_t BR_S  = st_t'(BR_ST + 2);

  // Elaboration-time parameter sanity checks.
  if (NUM_ST < 3 || NUM_ST > 16) begin : g_bad_num_st
    $error("param_seq_fsm: NUM_ST out of range 3..16");
  end
  if (YW < 1 || YW > 8) begin : g_bad_yw
    $error("param_seq_fsm: YW out of range 1..8");
  end
  if (BR_ST < 0 || BR_ST > NUM_ST - 3) begin : g_bad_br_st
    $error("param_seq_fsm: BR_ST out of range 0..NUM_ST-3");
  end
  if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
    $error("param_seq_fsm: DWELL out of range 1..255");
  end

  st_t           cur;
  st_t           nxt;
  logic          adv;      // this enabled cycle moves to a new state
  logic          illegal;  // encoding outside 0..NUM_ST-1 (non power-of-two NUM_ST)
  logic [YW-1:0] y_nxt;

  // Zero-extended compare so power-of-two NUM_ST just folds to 0.
  assign illegal = (32'(cur) >= NUM_ST);

`ifdef SEQ_DWELL_EN
  logic [7:0] dcnt;        // enabled cycles already spent in cur
  assign adv = enable && (dcnt == 8'(DWELL - 1));
`else
  assign adv = enable;
`endif

  always_comb begin
    nxt = cur;
    if (illegal)
      nxt = '0;
    else if (adv) begin
      if (cur == BR)
        nxt = control ? BR_T : BR_S;
      else if (cur == LAST)
        nxt = '0;
      else
        nxt = cur + 1'b1;
    end
  end

  // One extra bit so the +1 never overflows before truncation to YW.
  assign y_nxt = YW'({1'b0, nxt} + 1'b1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur  <= '0;
      y    <= YW'(1);
      wrap <= 1'b0;
`ifdef SEQ_DWELL_EN
      dcnt <= '0;
`endif
    end else begin
      cur  <= nxt;
      y    <= y_nxt;
      wrap <= !illegal && adv && (cur == LAST);
`ifdef SEQ_DWELL_EN
      if (illegal)
        dcnt <= '0;
      else if (enable)
        dcnt <= adv ? 8'd0 : 8'(dcnt + 8'd1);
`endif
    end
  end

  assign state = cur;

endmodule

// File: doc/param_seq_fsm.md
PARAM_SEQ_FSM -- requirements
Module: param_seq_fsm

Interface
REQ-001 Parameter NUM_ST, default 4, number of sequencer states; legal range 3..16.
REQ-002 Parameter YW, default 3, width of output y; legal range 1..8.
REQ-003 Parameter BR_ST, default 1, index of the single branch state; legal range 0..NUM_ST-3.
REQ-004 Parameter DWELL, default 1, enabled cycles per state when dwell is compiled in; legal range 1..255.
REQ-005 Localparam SW = ceil(log2(NUM_ST)), state encoding width.
REQ-006 Port clock, input, 1, sole clock; all flops rising-edge.
REQ-007 Port reset, input, 1; reset is asynchronous and active-low.
REQ-008 Port enable, input, 1, advance qualifier; 0 = hold.
REQ-009 Port control, input, 1, branch select, sampled only in BR_ST.
REQ-010 Port y, output, YW, registered sequencer output.
REQ-011 Port state, output, SW, current state index.
REQ-012 Port wrap, output, 1, registered one-cycle pulse on sequence wrap.

Function
REQ-013 State register cur; y SHALL always equal (cur+1) truncated to YW, registered on the same edge as cur (no combinational path from inputs to y).
REQ-014 A state advance SHALL occur on a rising edge where enable=1 and the advance condition holds (REQ-021/REQ-022).
REQ-015 On advance from cur==BR_ST: control=1 -> BR_ST+1; control=0 -> BR_ST+2.
REQ-016 On advance from cur==NUM_ST-1: next state 0.
REQ-017 On advance from any other state: cur+1.
REQ-018 With enable=0, cur, y, and any dwell count SHALL hold; wrap SHALL be 0.
REQ-019 wrap SHALL be 1 for exactly the one cycle after the edge that moves cur from NUM_ST-1 to 0, and 0 otherwise.
REQ-020 If cur >= NUM_ST (illegal encoding), the next rising edge SHALL force cur=0 and y=1 regardless of enable or control, with wrap=0.
REQ-021 Without dwell compiled in, every enabled cycle is an advance cycle and DWELL is ignored.
REQ-022 With dwell compiled in, an 8-bit counter SHALL count enabled cycles in the current state; advance occurs on the DWELL-th enabled cycle; the counter clears to 0 on advance; control is sampled only on the advance cycle.

Reset
REQ-023 While reset=0, cur=0, y=1, wrap=0, and the dwell counter=0, asynchronously and without a clock edge.
REQ-024 Reset assertion mid-sequence or mid-dwell SHALL abandon the sequence; after release, the first enabled advance leaves state 0.

Configuration
REQ-025 Macro SEQ_DWELL_EN: when defined, the dwell counter and REQ-022 apply; when undefined, no counter exists, REQ-021 applies, and the port list is unchanged.

Verification
REQ-026 Defaults; reset low, then release; enable=1, control=1 -> state 0,1,2,3,0; y 1,2,3,4,1; wrap=1 only in the cycle after the return to 0.
REQ-027 Defaults; enable=1, control=0 -> state 0,1,3,0; y 1,2,4,1; state 2 never visited.
REQ-028 Defaults; drop enable for 5 cycles while in state 2 -> state=2 and y=3 held for 5 cycles, wrap=0; the next enabled edge gives state 3.
REQ-029 Defaults; assert reset between edges while in state 3 -> state=0 and y=1 immediately, with no clock edge.
REQ-030 NUM_ST=8, YW=3, BR_ST=5, control=1 -> at state 7 y=0 (truncation); the next edge gives state 0, y=1, wrap pulse.
REQ-031 SEQ_DWELL_EN defined, DWELL=3 -> each state held 3 enabled cycles; enable low for 2 cycles mid-dwell extends that state to 5 cycles total.
